wb_stage: RTL
=============

# wb_stage

Writeback stage of the RV32I core, directly upstream of the register file. It accepts one retiring instruction per handshake from the memory stage and selects the writeback source: ALU result, aligned and extended load data, PC+4, or immediate. For loads it waits for the data-memory response, then drives the register file's write port (`rf_wen`/`rf_rd`/`rf_wdata`) from registered outputs. It also maintains a 64-bit retired-instruction counter.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- in_wb_sel  in  2  writeback source: 0 ALU, 1 LOAD, 2 PC4, 3 IMM
- in_funct3  in  3  load width/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU
- in_addr_lo  in  2  load byte address bits [1:0]
- in_alu_result  in  32  ALU result
- in_pc_plus4  in  32  PC+4 (JAL/JALR link)
- in_imm  in  32  U-type immediate (LUI)
- dmem_rvalid  in  1  load data valid, single-cycle pulse
- dmem_rdata  in  32  raw 32-bit aligned memory word
- rf_wen  out  1  register-file write enable, registered
- rf_rd  out  5  register-file write index, registered
- rf_wdata  out  32  register-file write data, registered
- retire_count  out  64  completed-instruction count

## Operation
- FSM states:
  - **IDLE**: `in_ready`=1.
  - **WAIT_LOAD**: `in_ready`=0; holds captured `rd`, `reg_write`, `funct3`, `addr_lo`.
- **Accept:** a transfer occurs when `in_valid && in_ready`.
- **Non-load accepted in IDLE:** the next cycle presents `rf_wen` = `reg_write && rd!=0`, `rf_rd`=rd, and `rf_wdata` = the selected source. The FSM stays in IDLE, so back-to-back throughput is 1 per cycle.
- **Load accepted in IDLE:** the FSM goes to WAIT_LOAD and `rf_wen`=0 next cycle.
- **WAIT_LOAD with `dmem_rvalid`=1:** the next cycle presents `rf_wen` = `reg_write && rd!=0` with the extracted data, and the FSM returns to IDLE.
- **Load extraction:**
  - Byte loads select byte `addr_lo`.
  - Halfword loads select half `addr_lo[1]`; `addr_lo[0]` is ignored.
  - LW ignores `addr_lo`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Illegal load funct3 (3, 6, 7):** `rf_wdata`=0, `rf_wen` forced 0, instruction still retires.
- **rd = x0:** `rf_wen` is never asserted; the instruction still retires.
- **Retire counter:** increments by 1 in the cycle the result registers update for each completed instruction, including `reg_write`=0 and `rd`=0 cases. It wraps modulo 2^64.
- **Stray response:** `dmem_rvalid` while in IDLE is ignored.
- **`rf_wen` deassertion:** whenever no instruction completes in a cycle, the next cycle has `rf_wen`=0. `rf_rd`/`rf_wdata` hold their last values.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1 from the cycle after `rst` is sampled, `rf_wen`=0, `rf_rd`=0, `rf_wdata`=0, `retire_count`=0.
- **Latency:**
  - Non-load: 1 cycle from accept to `rf_wen`.
  - Load: 1 cycle from `dmem_rvalid` to `rf_wen`.
- **Earliest response:** `dmem_rvalid` can arrive no earlier than the cycle after load acceptance.
- **`in_ready` timing:** `in_ready` is combinational from state only. A new instruction can be accepted in the same cycle the load result is written, because the FSM is IDLE that cycle.
- **Reset mid-operation:** `rst` in WAIT_LOAD returns the FSM to IDLE and discards the pending load. A `dmem_rvalid` arriving after reset is ignored, and no write or retire occurs for the discarded load.
- **Reset priority:** `rst` overrides a simultaneous accept or `dmem_rvalid`.

## Structure
- The shared package `rv32i_pkg` holds:
  - `wb_sel` encodings (`WB_ALU`, `WB_LOAD`, `WB_PC4`, `WB_IMM`);
  - load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`);
  - FSM state encoding.
- Sub-module: `load_align`, purely combinational: (`funct3`, `addr_lo`, `rdata`) -> 32-bit extended data plus an `illegal` flag.
- The FSM, output registers and retire counter stay in `wb_stage`.

## Test plan
- **ALU back-to-back:** after reset, three consecutive cycles of ALU writes to x5=0x11, x6=0x22, x7=0x33 -> `rf_wen`=1 on three consecutive cycles with matching rd/data; `retire_count`=3.
- **Load with wait:** LB, addr_lo=2, rd=x8; `dmem_rvalid` 3 cycles later with rdata=0x12_80_34_56 -> WAIT_LOAD holds `in_ready`=0; one cycle after rvalid, `rf_wdata`=0xFFFFFF80, `rf_rd`=8. Repeat as LBU -> 0x00000080.
- **Halfword and word:** LH with addr_lo=3, rdata=0x8001_7FFF -> 0xFFFF8001; LHU with addr_lo=0 -> 0x00007FFF; LW with addr_lo=1 -> 0x80017FFF.
- **x0 and sources:** LUI to x0 with imm=0x12345000 -> `rf_wen`=0, retire increments; JAL with rd=x1, pc_plus4=0x104 -> writes 0x104.
- **Illegal funct3:** funct3=3 load -> `rf_wen`=0 after rvalid, retire increments.
- **Reset mid-load:** load accepted, `rst` pulsed in WAIT_LOAD, then late rvalid -> no write, `retire_count`=0, `in_ready`=1, next ALU instruction completes normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: writeback source select, load funct3 values and
// the writeback-stage FSM state encoding.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: picks the byte/half/word out of the aligned
// memory word and sign- or zero-extends it; flags unsupported funct3 values.
module load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_illegal
);

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
    logic signed [XLEN-1:0] s;
    s = b;
    return s;
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
    logic signed [XLEN-1:0] s;
    s = h;
    return s;
  endfunction

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  // Halfword loads are naturally aligned, so only addr_lo[1] picks the half.
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data    = '0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_LB:   o_data = sext8(w_byte);
      F3_LH:   o_data = sext16(w_half);
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: selects the writeback source, waits for load data,
// drives the register-file write port from registers and counts retirements.
module wb_stage
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [63:0]     retire_count
);

  logic [0:0]      r_state;
  logic [4:0]      r_ld_rd;
  logic            r_ld_reg_write;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_addr_lo;

  logic            r_rf_wen;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wdata;
  logic [63:0]     r_retire_count;

  logic            w_accept;
  logic            w_is_load;
  logic            w_done_direct;
  logic            w_done_load;
  logic [XLEN-1:0] w_direct_data;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_illegal;

  assign in_ready      = (r_state == ST_IDLE);
  assign w_accept      = in_valid && in_ready;
  assign w_is_load     = (in_wb_sel == WB_LOAD);
  assign w_done_direct = w_accept && !w_is_load;
  assign w_done_load   = (r_state == ST_WAIT_LOAD) && dmem_rvalid;

  always_comb begin
    w_direct_data = in_alu_result;
    case (in_wb_sel)
      WB_PC4:  w_direct_data = in_pc_plus4;
      WB_IMM:  w_direct_data = in_imm;
      default: w_direct_data = in_alu_result;
    endcase
  end

  // Extraction always uses the captured load attributes: it only matters in WAIT_LOAD.
  load_align u_load_align (
    .i_funct3  (r_ld_funct3),
    .i_addr_lo (r_ld_addr_lo),
    .i_rdata   (dmem_rdata),
    .o_data    (w_ld_data),
    .o_illegal (w_ld_illegal)
  );

  // FSM and pending-load capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ld_rd        <= '0;
      r_ld_reg_write <= 1'b0;
      r_ld_funct3    <= '0;
      r_ld_addr_lo   <= '0;
    end else begin
      if (w_accept && w_is_load) begin
        r_state        <= ST_WAIT_LOAD;
        r_ld_rd        <= in_rd;
        r_ld_reg_write <= in_reg_write;
        r_ld_funct3    <= in_funct3;
        r_ld_addr_lo   <= in_addr_lo;
      end else if (w_done_load) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Register-file write port and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_wen       <= 1'b0;
      r_rf_rd        <= '0;
      r_rf_wdata     <= '0;
      r_retire_count <= '0;
    end else if (w_done_direct) begin
      r_rf_wen       <= in_reg_write && (in_rd != 5'd0);
      r_rf_rd        <= in_rd;
      r_rf_wdata     <= w_direct_data;
      r_retire_count <= r_retire_count + 64'd1;
    end else if (w_done_load) begin
      r_rf_wen       <= r_ld_reg_write && (r_ld_rd != 5'd0) && !w_ld_illegal;
      r_rf_rd        <= r_ld_rd;
      r_rf_wdata     <= w_ld_illegal ? '0 : w_ld_data;
      r_retire_count <= r_retire_count + 64'd1;
    end else begin
      r_rf_wen <= 1'b0;
    end
  end

  assign rf_wen       = r_rf_wen;
  assign rf_rd        = r_rf_rd;
  assign rf_wdata     = r_rf_wdata;
  assign retire_count = r_retire_count;

endmodule
